float_exponent_to_int: RTL and testbench

Converts an IEEE-754 single-precision exponent value into an unsigned integer for the exponent_operation stage, which sits directly downstream. The block is a multi-cycle, shift-per-cycle converter with a start/output_ready handshake. Its result is zero-extended to DATA_WIDTH so it can drive inp_exponent directly. It also raises status flags for non-integer-friendly inputs.

---
 rtl/float_exponent_to_int_if.sv | 25 ++
 rtl/float_exponent_to_int.sv | 164 ++++++++++++++++
 tb/tb_float_exponent_to_int.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/float_exponent_to_int_if.sv
// Request/result bundle between a float-to-int converter and its driver.
// The driver owns start/inp_float; the converter owns busy, the ready pulse, result and flags.
interface float_exponent_to_int_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [DATA_WIDTH-1:0] inp_float;
  logic                  busy;
  logic                  output_ready;
  logic [DATA_WIDTH-1:0] out_int;
  logic                  out_zero;
  logic                  out_sat;
  logic                  out_neg;
  logic                  out_invalid;

  modport master (
    output start, inp_float,
    input  busy, output_ready, out_int, out_zero, out_sat, out_neg, out_invalid
  );

  modport slave (
    input  start, inp_float,
    output busy, output_ready, out_int, out_zero, out_sat, out_neg, out_invalid
  );
endinterface

// File: rtl/float_exponent_to_int.sv
// IEEE-754 single to truncated unsigned int, one shift per cycle; latency n+2 (2..25) cycles.
// No backpressure: start is only sampled in IDLE, requests while busy are dropped.
module float_exponent_to_int #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  float_exponent_to_int_if.slave conv
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_SHIFT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [23:0] SAT_VAL = 24'((1 << OUT_WIDTH) - 1);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   float_q, float_d;
  logic [23:0]             shift_q, shift_d;
  logic [4:0]              cnt_q, cnt_d;
  logic                    pend_sat_q, pend_sat_d;
  logic                    pend_neg_q, pend_neg_d;
  logic                    pend_inv_q, pend_inv_d;
  logic [OUT_WIDTH-1:0]    out_int_q, out_int_d;
  logic                    zero_q, zero_d;
  logic                    sat_q, sat_d;
  logic                    neg_q, neg_d;
  logic                    inv_q, inv_d;
  logic                    rdy_q, rdy_d;

  logic                    sign_f;
  logic [7:0]              exp_f;
  logic [23:0]             sig_f;
  logic signed [9:0]       k_s;
  logic [4:0]              shift_n;

  assign sign_f  = float_q[31];
  assign exp_f   = float_q[30:23];
  assign sig_f   = {1'b1, float_q[22:0]};
  assign k_s     = $signed({2'b00, exp_f}) - 10'sd127;
  // Only meaningful on the shifting path, where 0 <= k <= 23 fits in five bits.
  assign shift_n = 5'd23 - k_s[4:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      float_q    <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      pend_sat_q <= 1'b0;
      pend_neg_q <= 1'b0;
      pend_inv_q <= 1'b0;
      out_int_q  <= '0;
      zero_q     <= 1'b0;
      sat_q      <= 1'b0;
      neg_q      <= 1'b0;
      inv_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      float_q    <= float_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      pend_sat_q <= pend_sat_d;
      pend_neg_q <= pend_neg_d;
      pend_inv_q <= pend_inv_d;
      out_int_q  <= out_int_d;
      zero_q     <= zero_d;
      sat_q      <= sat_d;
      neg_q      <= neg_d;
      inv_q      <= inv_d;
      rdy_q      <= rdy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    float_d    = float_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    pend_sat_d = pend_sat_q;
    pend_neg_d = pend_neg_q;
    pend_inv_d = pend_inv_q;
    out_int_d  = out_int_q;
    zero_d     = zero_q;
    sat_d      = sat_q;
    neg_d      = neg_q;
    inv_d      = inv_q;
    rdy_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (conv.start) begin
          float_d = conv.inp_float;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        pend_sat_d = 1'b0;
        pend_neg_d = 1'b0;
        pend_inv_d = 1'b0;
        cnt_d      = '0;
        state_d    = S_DONE;
        // Special cases park their final result in the shift register so DONE is uniform.
        if (exp_f == 8'hFF) begin
          shift_d    = SAT_VAL;
          pend_inv_d = 1'b1;
        end else if (exp_f == 8'h00) begin
          shift_d = '0;
        end else if (sign_f) begin
          shift_d    = '0;
          pend_neg_d = 1'b1;
        end else if (k_s < 10'sd0) begin
          shift_d = '0;
        end else if (k_s >= $signed(10'(OUT_WIDTH))) begin
          shift_d    = SAT_VAL;
          pend_sat_d = 1'b1;
        end else begin
          shift_d = sig_f;
          cnt_d   = shift_n;
          if (shift_n != 5'd0) begin
            state_d = S_SHIFT;
          end
        end
      end

      S_SHIFT: begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        out_int_d = shift_q[OUT_WIDTH-1:0];
        zero_d    = (shift_q[OUT_WIDTH-1:0] == '0);
        sat_d     = pend_sat_q;
        neg_d     = pend_neg_q;
        inv_d     = pend_inv_q;
        rdy_d     = 1'b1;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign conv.busy         = (state_q != S_IDLE);
  assign conv.output_ready = rdy_q;
  assign conv.out_int      = {{(DATA_WIDTH-OUT_WIDTH){1'b0}}, out_int_q};
  assign conv.out_zero     = zero_q;
  assign conv.out_sat      = sat_q;
  assign conv.out_neg      = neg_q;
  assign conv.out_invalid  = inv_q;

endmodule

// File: tb/tb_float_exponent_to_int.sv
// Directed and random checks of float_exponent_to_int against an arithmetic reference model.
module tb_float_exponent_to_int;

  localparam int OUT_W = 3;
  localparam logic [31:0] MAXV = 32'((1 << OUT_W) - 1);

  logic clock;
  logic reset_n;
  int   n_assert;
  int   n_fail;

  float_exponent_to_int_if #(.DATA_WIDTH(32)) conv ();

  float_exponent_to_int #(.DATA_WIDTH(32), .OUT_WIDTH(OUT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .conv    (conv)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: the float value is sig * 2^(k-23); floor it with plain integer arithmetic.
  function automatic void model(input logic [31:0] f, output logic [31:0] res,
                                output logic s, output logic ng, output logic inv,
                                output int lat);
    int e;
    int k;
    longint unsigned v;
    e = int'(f[30:23]);
    k = e - 127;
    s = 1'b0; ng = 1'b0; inv = 1'b0; lat = 2; res = '0;
    if (e == 255) begin
      res = MAXV; inv = 1'b1;
    end else if (e == 0) begin
      res = '0;
    end else if (f[31]) begin
      ng = 1'b1;
    end else if (k < 0) begin
      res = '0;
    end else begin
      v = longint'({1'b1, f[22:0]});
      if (k >= 40) begin
        res = MAXV; s = 1'b1;
      end else begin
        v = (k >= 23) ? (v << (k - 23)) : (v >> (23 - k));
        if (v > longint'(MAXV)) begin
          res = MAXV; s = 1'b1;
        end else begin
          res = 32'(v);
          lat = 2 + (23 - k);
        end
      end
    end
  endfunction

  task automatic run_conv(input logic [31:0] f, input string tag);
    logic [31:0] eres;
    logic es, en, ei;
    int elat, lat, busy_cnt;
    model(f, eres, es, en, ei, elat);
    @(posedge clock); #1;
    conv.inp_float = f;
    conv.start     = 1'b1;
    @(posedge clock); #1;
    conv.start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!conv.output_ready && lat < 40) begin
      if (conv.busy) busy_cnt++;
      @(posedge clock); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(elat));
    chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(elat));
    chk({tag, ".out_int"}, conv.out_int, eres);
    chk({tag, ".out_zero"}, {31'd0, conv.out_zero}, {31'd0, eres == 0});
    chk({tag, ".out_sat"}, {31'd0, conv.out_sat}, {31'd0, es});
    chk({tag, ".out_neg"}, {31'd0, conv.out_neg}, {31'd0, en});
    chk({tag, ".out_invalid"}, {31'd0, conv.out_invalid}, {31'd0, ei});
    chk({tag, ".busy_at_ready"}, {31'd0, conv.busy}, 32'd0);
    @(posedge clock); #1;
    chk({tag, ".ready_pulse_ends"}, {31'd0, conv.output_ready}, 32'd0);
    chk({tag, ".out_int_held"}, conv.out_int, eres);
  endtask

  initial begin
    int pulses;
    logic [31:0] rf;
    logic [7:0]  re;
    n_assert = 0;
    n_fail   = 0;
    conv.start     = 1'b0;
    conv.inp_float = '0;
    reset_n        = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst.output_ready", {31'd0, conv.output_ready}, 32'd0);
    chk("rst.busy", {31'd0, conv.busy}, 32'd0);
    chk("rst.out_int", conv.out_int, 32'd0);
    chk("rst.flags", {28'd0, conv.out_zero, conv.out_sat, conv.out_neg, conv.out_invalid}, 32'd0);
    reset_n = 1'b1;

    // Directed values
    run_conv(32'h40400000, "f3p0");
    run_conv(32'h40B80000, "f5p75");
    run_conv(32'h3F000000, "f0p5");
    run_conv(32'h41000000, "f8p0");
    run_conv(32'h7FC00000, "nan");
    run_conv(32'h7F800000, "inf");
    run_conv(32'hC0000000, "neg2p0");
    run_conv(32'h80000000, "negzero");
    run_conv(32'h00400000, "subnormal");
    run_conv(32'h40F00000, "f7p5");

    // Start while busy is dropped
    @(posedge clock); #1;
    conv.inp_float = 32'h40400000;
    conv.start     = 1'b1;
    @(posedge clock); #1;
    conv.start = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 5) begin
        conv.inp_float = 32'h40E00000;
        conv.start     = 1'b1;
      end else begin
        conv.start = 1'b0;
      end
      @(posedge clock); #1;
      if (conv.output_ready) pulses++;
    end
    conv.start = 1'b0;
    chk("ignore.pulses", 32'(pulses), 32'd1);
    chk("ignore.out_int", conv.out_int, 32'd3);
    run_conv(32'h40E00000, "f7p0");

    // Reset mid-conversion
    @(posedge clock); #1;
    conv.inp_float = 32'h40400000;
    conv.start     = 1'b1;
    @(posedge clock); #1;
    conv.start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort.out_int", conv.out_int, 32'd0);
    chk("abort.busy", {31'd0, conv.busy}, 32'd0);
    chk("abort.ready", {31'd0, conv.output_ready}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (conv.output_ready) pulses++;
    end
    chk("abort.no_pulse", 32'(pulses), 32'd0);
    chk("abort.idle", {31'd0, conv.busy}, 32'd0);
    run_conv(32'h3F800000, "f1p0");

    // Random values concentrated around the representable range
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0:       re = 8'hFF;
        1:       re = 8'h00;
        2:       re = 8'($urandom_range(0, 255));
        default: re = 8'($urandom_range(118, 133));
      endcase
      rf = {1'($urandom_range(0, 3) == 0), re, 23'($urandom)};
      run_conv(rf, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
